light_nlvl_ctrl: RTL
====================

# light_nlvl_ctrl

Parametrised N-level light controller with on-chip button conditioning: synchronises two raw push-buttons, converts presses to single steps, and moves a brightness level up or down with saturate or wrap-around limits. It replaces the fixed 4-level controller plus its separate pulse converters as one self-contained block driving the light output. Optional auto-repeat steps the level continuously while a button is held.

## Interface

- LEVELS, 4: number of brightness levels, ≥2; level 0 = off
- LW, $clog2(LEVELS): light width; derived, not overridden
- WRAP, 0: 0 = saturate at 0 / LEVELS-1; 1 = wrap around
- SYNC_STAGES, 2: synchroniser flops per button, ≥2
- HOLD_CYC, 1000: held cycles before the first auto-repeat step, ≥2
- RPT_CYC, 250: cycles between auto-repeat steps, ≥2

- clk  in  1  rising-edge clock; the only clock
- reset  in  1  reset, asynchronous assert, active-low; synchronous deassert is the system's job
- btn_up  in  1  raw level, asynchronous, active-high
- btn_down  in  1  raw level, asynchronous, active-high
- light  out  LW  current level, registered
- at_max  out  1  light == LEVELS-1, registered
- at_min  out  1  light == 0, registered
- step  out  1  one-cycle pulse on the cycle light changes

## Operation

- Reset (reset low): light=0, at_min=1, at_max=0, step=0, all sync/edge flops 0, FSM IDLE, counter 0. Takes effect immediately, including mid-repeat.
- Each button: SYNC_STAGES-flop synchroniser, then rising-edge detect → one-cycle press pulse.
- Request: up = up_pulse & ~down_sync; down = down_pulse & ~up_sync. Both buttons synchronised high → no request.
- Up request: light+1; at LEVELS-1 → stays (WRAP=0) or goes to 0 (WRAP=1). Down request mirrors: at 0 → stays or goes to LEVELS-1.
- step=1 only if light actually changes. Saturated request: no change, no step.
- at_max/at_min update in the same cycle as light.
- Arithmetic in LW bits, compared against LEVELS-1 explicitly; codes ≥LEVELS are never produced, even when LEVELS is not a power of two.
- Auto-repeat FSM (feature-gated): IDLE, HOLD, REPEAT.
  - IDLE → HOLD on a valid press pulse; counter cleared.
  - HOLD: counter counts; at HOLD_CYC-1 → REPEAT, one step issued, counter cleared.
  - REPEAT: one step every RPT_CYC cycles.
  - Any state → IDLE when the held button drops or the other button rises. A fresh edge is needed to restart.
  - Repeat steps obey saturate/wrap rules like single presses.

## Timing

- Press latency: light/step change on the (SYNC_STAGES+1)-th rising clk edge that samples the button high (3rd edge for default).
- Release detection also lags by SYNC_STAGES cycles.
- Press held N cycles gives exactly 1 step when N < HOLD_CYC (auto-repeat on or off).
- With auto-repeat, a continuous hold gives steps at t0, t0+HOLD_CYC, then every RPT_CYC after that. t0 = first step.
- Button glitches shorter than one clk period may be missed. No debounce filter; the system supplies debounced buttons.

## Configuration

- LIGHT_AUTOREPEAT_EN defined: FSM and counter built; behaviour as above.
- Undefined: no FSM or counter; exactly one step per rising edge; HOLD_CYC/RPT_CYC ignored.

## Structure

- Package light_pkg: FSM state enum (IDLE, HOLD, REPEAT) and the counter-width helper constant/function.
- Sub-module btn_sync_edge (synchroniser + edge detect; outputs sync level and press pulse), instantiated twice.

## Test plan

- Reset low mid-operation with light=2 → light=0, at_min=1, at_max=0, step=0 at once. Stays so while reset is low.
- LEVELS=4, WRAP=0: 5 separate up presses from 0 → light 1,2,3,3,3. step on first 3 only; at_max=1 after the 3rd.
- LEVELS=5, WRAP=1: down press at 0 → 4, then up → 0. Values ≥5 never appear.
- btn_up held and btn_down pressed during the hold → no step on down. Up press with down held → no step.
- Latency, SYNC_STAGES=2: btn_up rises before edge E0 → step high and light updated after edge E2, exactly one cycle wide.
- LIGHT_AUTOREPEAT_EN, HOLD_CYC=10, RPT_CYC=4, up held 30 cycles → steps at t0, t0+10, t0+14, t0+18, … until release. Undefined → single step only.

Source files
------------

// File: rtl/light_pkg.sv
// light_pkg -- shared types and helpers for the N-level light controller.
//
// Contents:
//   rpt_state_e : auto-repeat FSM state (IDLE, HOLD, REPEAT)
//   cnt_width() : bits needed by the auto-repeat counter, which only ever
//                 holds values 0 .. max(HOLD_CYC, RPT_CYC)-1
package light_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    function automatic int cnt_width(input int hold_cyc, input int rpt_cyc);
        int mx;
        mx = (hold_cyc > rpt_cyc) ? hold_cyc : rpt_cyc;
        if (mx < 2) begin
            return 1;
        end
        return $clog2(mx);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge -- synchroniser plus rising-edge detector for one raw button.
//
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, clears every flop
//   btn_i   : raw asynchronous button level, active-high
//   sync_o  : button level after SYNC_STAGES flops
//   press_o : one-cycle pulse in the first cycle sync_o is high
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic sync_o,
    output logic press_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o  = sync_q[SYNC_STAGES-1];
    // Combinational pulse so the level register can act on it at the next edge.
    assign press_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/light_nlvl_ctrl.sv
// light_nlvl_ctrl -- N-level light controller with button conditioning.
//
// Two raw buttons are synchronised and edge-detected; each valid press moves
// the brightness level one step up or down, saturating or wrapping at the
// ends. Optional auto-repeat (build macro LIGHT_AUTOREPEAT_EN) keeps stepping
// while a button stays held: first repeat HOLD_CYC cycles after the press
// step, then every RPT_CYC cycles.
//
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   btn_up   : raw up button, active-high
//   btn_down : raw down button, active-high
//   light    : current level (0 = off), registered
//   at_max   : light == LEVELS-1, registered
//   at_min   : light == 0, registered
//   step     : one-cycle pulse in the cycle light changed
module light_nlvl_ctrl #(
    parameter  int LEVELS      = 4,
    parameter  int WRAP        = 0,
    parameter  int SYNC_STAGES = 2,
    parameter  int HOLD_CYC    = 1000,
    parameter  int RPT_CYC     = 250,
    localparam int LW          = $clog2(LEVELS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_up,
    input  logic          btn_down,
    output logic [LW-1:0] light,
    output logic          at_max,
    output logic          at_min,
    output logic          step
);

    import light_pkg::*;

    if (LEVELS < 2 || SYNC_STAGES < 2 || HOLD_CYC < 2 || RPT_CYC < 2 ||
        (WRAP != 0 && WRAP != 1)) begin : g_bad_params
        $error("light_nlvl_ctrl: illegal parameter value");
    end

    localparam logic [LW-1:0] MAX_LVL = LW'(LEVELS - 1);

    logic up_sync, up_press, dn_sync, dn_press;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_up (
        .clk_i   (clk),
        .rst_ni  (reset),
        .btn_i   (btn_up),
        .sync_o  (up_sync),
        .press_o (up_press)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dn (
        .clk_i   (clk),
        .rst_ni  (reset),
        .btn_i   (btn_down),
        .sync_o  (dn_sync),
        .press_o (dn_press)
    );

    // A press only counts while the opposite button is released.
    logic up_req, dn_req;
    assign up_req = up_press & ~dn_sync;
    assign dn_req = dn_press & ~up_sync;

    logic mv_req;  // move the level this cycle
    logic mv_up;   // direction of that move

`ifdef LIGHT_AUTOREPEAT_EN
    localparam int CW = cnt_width(HOLD_CYC, RPT_CYC);

    rpt_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          dir_up_q;
    logic          abort, rpt_fire;

    // Leaving the hold: the held button dropped or the other one is high.
    assign abort = dir_up_q ? (~up_sync | dn_sync) : (~dn_sync | up_sync);

    always_comb begin
        rpt_fire = 1'b0;
        if (!(up_req || dn_req) && !abort) begin
            case (state_q)
                HOLD:    rpt_fire = (cnt_q == CW'(HOLD_CYC - 1));
                REPEAT:  rpt_fire = (cnt_q == CW'(RPT_CYC - 1));
                default: rpt_fire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dir_up_q <= 1'b0;
        end else if (up_req || dn_req) begin
            // A fresh valid press always (re)starts the hold timing.
            state_q  <= HOLD;
            cnt_q    <= '0;
            dir_up_q <= up_req;
        end else begin
            case (state_q)
                HOLD, REPEAT: begin
                    if (abort) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (rpt_fire) begin
                        state_q <= REPEAT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign mv_req = up_req | dn_req | rpt_fire;
    assign mv_up  = (up_req || dn_req) ? up_req : dir_up_q;
`else
    assign mv_req = up_req | dn_req;
    assign mv_up  = up_req;
`endif

    logic [LW-1:0] light_d, light_q;
    logic          at_max_q, at_min_q, step_q;

    always_comb begin
        light_d = light_q;
        if (mv_req) begin
            if (mv_up) begin
                if (light_q == MAX_LVL) begin
                    light_d = (WRAP != 0) ? '0 : light_q;
                end else begin
                    light_d = light_q + LW'(1);
                end
            end else begin
                if (light_q == '0) begin
                    light_d = (WRAP != 0) ? MAX_LVL : light_q;
                end else begin
                    light_d = light_q - LW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            light_q  <= '0;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
            step_q   <= 1'b0;
        end else begin
            light_q  <= light_d;
            at_max_q <= (light_d == MAX_LVL);
            at_min_q <= (light_d == '0);
            step_q   <= (light_d != light_q);
        end
    end

    assign light  = light_q;
    assign at_max = at_max_q;
    assign at_min = at_min_q;
    assign step   = step_q;

endmodule
